// File: rtl/data_cache_if.sv
// Bus bundle for the data cache. It carries the CPU load/store handshake
// and the block-memory handshake. The cache uses the slave view. The CPU
// and memory environment use the master view.
interface data_cache_if;
  // CPU side
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  // Memory side
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// Read hits return data in the same cycle. Write hits commit at the next
// rising edge. A miss first writes back a dirty victim line, then fetches
// the missing line. The access then completes in IDLE as a hit.
module data_cache #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input logic          CLK,
  input logic          RESET,
  data_cache_if.slave  bus
);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int TAG_W  = 8 - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_FETCH  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Line storage. Only the valid/dirty flags are reset.
  logic [LINE_W-1:0] data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]  tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             req;
  logic             hit;
  logic             write_hit;
  logic             fill;

  assign addr_tag = bus.ADDRESS[7 -: TAG_W];
  assign addr_idx = bus.ADDRESS[OFF_W +: IDX_W];
  assign addr_off = bus.ADDRESS[OFF_W-1:0];

  assign req       = bus.READ || bus.WRITE;
  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  // A store commits only in IDLE. This is exactly when BUSYWAIT is low for a write.
  assign write_hit = (state_q == IDLE) && bus.WRITE && hit;
  assign fill      = (state_q == MEM_FETCH) && !bus.MEM_BUSYWAIT;

  // BUSYWAIT is gated by reset so that the stall releases as soon as reset asserts.
  assign bus.BUSYWAIT = RESET && req && !((state_q == IDLE) && hit);

  // Load data: the addressed byte of the indexed line on a pure read hit, otherwise zero.
  always_comb begin
    bus.READDATA = '0;
    if (bus.READ && !bus.WRITE && hit) begin
      bus.READDATA = data_q[addr_idx][{addr_off, 3'b000} +: 8];
    end
  end

  // State register. Reset abandons any in-flight memory transaction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory strobes. Addresses and data come from state
  // and the stable CPU address, so they hold for the whole state.
  always_comb begin
    state_d           = state_q;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = MEM_FETCH;
          end
        end
      end
      WRITE_BACK: begin
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
        bus.MEM_WRITEDATA = data_q[addr_idx];
        if (!bus.MEM_BUSYWAIT) begin
          state_d = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = {addr_tag, addr_idx};
        if (!bus.MEM_BUSYWAIT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valid/dirty flags. A fill leaves the line clean. A store hit marks it dirty.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[addr_idx] <= 1'b1;
      dirty_q[addr_idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[addr_idx] <= 1'b1;
    end
  end

  // Line data and tags. A fill writes the whole block. A store hit writes one byte.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[addr_idx] <= bus.MEM_READDATA;
      tag_q[addr_idx]  <= addr_tag;
    end else if (write_hit) begin
      data_q[addr_idx][{addr_off, 3'b000} +: 8] <= bus.WRITEDATA;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache. The stimulus pushes the expected CPU
// completions and memory strobes into queues. Independent monitors pop and
// compare them when the DUT completes an access or raises a strobe.
// The memory model holds the bus busy for MEM_LAT-1 cycles. It then
// completes in the cycle after that.
module tb_data_cache;
  localparam int MEM_LAT = 5;

  logic CLK;
  logic RESET;
  data_cache_if bus ();

  data_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       chk_data;
    logic [7:0] rdata;
    int         stall;
  } txn_t;

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } memtxn_t;

  txn_t    txn_q[$];
  memtxn_t mem_q[$];

  // ---------------- memory model ----------------
  logic [31:0] mem [64];
  int          mem_cnt;
  logic        strobe;

  assign strobe           = bus.MEM_READ || bus.MEM_WRITE;
  assign bus.MEM_BUSYWAIT = strobe && (mem_cnt != MEM_LAT - 1);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{i[7:0]}};
    mem[6'h00] = 32'h4433_2211;
    mem[6'h08] = 32'h8877_6655;
    mem[6'h11] = 32'h0F0E_0D0C;
    mem_cnt = 0;
    forever begin
      @(posedge CLK);
      if (strobe && bus.MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
      if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_txn(input logic chk_data, input logic [7:0] rdata, input int stall);
    txn_t t;
    t.chk_data = chk_data;
    t.rdata    = rdata;
    t.stall    = stall;
    txn_q.push_back(t);
  endtask

  task automatic exp_mem(input logic is_wr, input logic [5:0] addr, input logic [31:0] wdata);
    memtxn_t m;
    m.is_wr = is_wr;
    m.addr  = addr;
    m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    int n;
    @(posedge CLK); #1;
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.BUSYWAIT && n < 100);
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, n);
    end
    @(posedge CLK); #1;
    bus.READ = 1'b0; bus.WRITE = 1'b0;
  endtask

  // ---------------- CPU completion monitor ----------------
  initial begin
    int   stall_cnt;
    txn_t e;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (RESET && (bus.READ || bus.WRITE)) begin
        if (bus.BUSYWAIT) begin
          stall_cnt++;
        end else begin
          checks++;
          if (txn_q.size() == 0) begin
            errors++;
            $display("FAIL txn_unexpected: addr %0h completed with nothing expected", bus.ADDRESS);
          end else begin
            e = txn_q.pop_front();
            if (stall_cnt != e.stall) begin
              errors++;
              $display("FAIL txn_stall: addr %0h stalled %0d expected %0d", bus.ADDRESS, stall_cnt, e.stall);
            end
            if (e.chk_data) begin
              checks++;
              if (bus.READDATA !== e.rdata) begin
                errors++;
                $display("FAIL txn_rdata: addr %0h got %0h expected %0h", bus.ADDRESS, bus.READDATA, e.rdata);
              end
            end
            $display("txn rd=%0b wr=%0b addr=%02h rdata=%02h stall=%0d",
                     bus.READ, bus.WRITE, bus.ADDRESS, bus.READDATA, stall_cnt);
          end
          stall_cnt = 0;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  // ---------------- memory strobe monitor ----------------
  initial begin
    logic    prev_rd, prev_wr, rd, wr;
    memtxn_t m;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge CLK);
      rd = bus.MEM_READ;
      wr = bus.MEM_WRITE;
      if ((rd && !prev_rd) || (wr && !prev_wr)) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: strobe wr=%0b addr %0h with nothing expected", wr, bus.MEM_ADDRESS);
        end else begin
          m = mem_q.pop_front();
          if (wr !== m.is_wr || bus.MEM_ADDRESS !== m.addr) begin
            errors++;
            $display("FAIL mem_strobe: wr=%0b addr %0h expected wr=%0b addr %0h",
                     wr, bus.MEM_ADDRESS, m.is_wr, m.addr);
          end
          if (m.is_wr) begin
            checks++;
            if (bus.MEM_WRITEDATA !== m.wdata) begin
              errors++;
              $display("FAIL mem_wdata: got %0h expected %0h", bus.MEM_WRITEDATA, m.wdata);
            end
          end
          $display("mem %s addr=%02h wdata=%08h", wr ? "write" : "read ", bus.MEM_ADDRESS, bus.MEM_WRITEDATA);
        end
      end
      prev_rd = rd;
      prev_wr = wr;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.READ = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;
    RESET = 1'b0;
    // Reset state with a request pending: everything must be quiet.
    @(negedge CLK);
    chk("rst_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
    chk("rst_mem_read", {31'b0, bus.MEM_READ}, 32'h0);
    chk("rst_mem_write", {31'b0, bus.MEM_WRITE}, 32'h0);
    chk("rst_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'h0);
    chk("rst_mem_wdata", bus.MEM_WRITEDATA, 32'h0);
    chk("rst_readdata", {24'b0, bus.READDATA}, 32'h0);
    bus.READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Clean miss on line 0, then a same-line hit.
    exp_mem(1'b0, 6'h00, 32'h0);
    exp_txn(1'b1, 8'h11, MEM_LAT + 1);
    access(1'b1, 1'b0, 8'h00, 8'h00);
    exp_txn(1'b1, 8'h44, 0);
    access(1'b1, 1'b0, 8'h03, 8'h00);

    // Write hit, then read it back.
    exp_txn(1'b0, 8'h00, 0);
    access(1'b0, 1'b1, 8'h01, 8'hAA);
    exp_txn(1'b1, 8'hAA, 0);
    access(1'b1, 1'b0, 8'h01, 8'h00);

    // Conflict on line 0 with dirty victim: write-back then fetch.
    exp_mem(1'b1, 6'h00, 32'h4433_AA11);
    exp_mem(1'b0, 6'h08, 32'h0);
    exp_txn(1'b1, 8'h66, 2 * MEM_LAT + 1);
    access(1'b1, 1'b0, 8'h21, 8'h00);

    // Write miss on a clean (invalid) line: fetch only, then byte merged.
    exp_mem(1'b0, 6'h11, 32'h0);
    exp_txn(1'b0, 8'h00, MEM_LAT + 1);
    access(1'b0, 1'b1, 8'h44, 8'h5C);
    exp_txn(1'b1, 8'h5C, 0);
    access(1'b1, 1'b0, 8'h44, 8'h00);

    // Evict the dirty line 1, then refetch it to see the written-back data.
    exp_mem(1'b1, 6'h11, 32'h0F0E_0D5C);
    exp_mem(1'b0, 6'h19, 32'h0);
    exp_txn(1'b1, 8'h19, 2 * MEM_LAT + 1);
    access(1'b1, 1'b0, 8'h64, 8'h00);
    exp_mem(1'b0, 6'h11, 32'h0);
    exp_txn(1'b1, 8'h0E, MEM_LAT + 1);
    access(1'b1, 1'b0, 8'h46, 8'h00);

    // Reset during a fetch: strobe and stall drop immediately.
    exp_mem(1'b0, 6'h20, 32'h0);
    @(posedge CLK); #1;
    bus.READ = 1'b1; bus.ADDRESS = 8'h80;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.MEM_READ && n < 50);
    chk("fetch_started", {31'b0, bus.MEM_READ}, 32'h1);
    @(negedge CLK); #2;
    RESET = 1'b0;
    #1;
    chk("midrst_mem_read", {31'b0, bus.MEM_READ}, 32'h0);
    chk("midrst_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
    chk("midrst_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'h0);
    @(posedge CLK); #1;
    bus.READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Same address misses again after reset.
    exp_mem(1'b0, 6'h20, 32'h0);
    exp_txn(1'b1, 8'h20, MEM_LAT + 1);
    access(1'b1, 1'b0, 8'h80, 8'h00);

    // READ and WRITE together: the write wins.
    exp_txn(1'b0, 8'h00, 0);
    access(1'b1, 1'b1, 8'h80, 8'h77);
    exp_txn(1'b1, 8'h77, 0);
    access(1'b1, 1'b0, 8'h80, 8'h00);

    repeat (3) @(posedge CLK);
    chk("txn_queue_drained", txn_q.size(), 32'h0);
    chk("mem_queue_drained", mem_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and 32-bit-block data memory.
- The ALU result drives ADDRESS for loads and stores. The register file's read data drives WRITEDATA. READDATA returns to register-file writeback.
- BUSYWAIT stalls the PC and register writes until the access completes.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; fixes index width at 3.
- BLOCK_BYTES, 4, bytes per line; fixes offset width at 2.
- Tag width is derived: 8 - 3 - 2 = 3.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  CPU load request.
- WRITE  input  1  CPU store request.
- ADDRESS  input  8  byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data.
- BUSYWAIT  output  1  CPU stall.
- MEM_READ  output  1  memory block-read strobe.
- MEM_WRITE  output  1  memory block-write strobe.
- MEM_ADDRESS  output  6  block address {tag, index}.
- MEM_WRITEDATA  output  32  block being written back; byte 0 in bits [7:0].
- MEM_READDATA  input  32  block returned by memory; byte 0 in bits [7:0].
- MEM_BUSYWAIT  input  1  memory busy; memory asserts it in the same cycle it sees a strobe and drops it in the cycle its transaction completes.

Behaviour:
- Reset (RESET low, asynchronous, takes effect immediately):
  - All valid and dirty bits cleared; state = IDLE.
  - MEM_READ = MEM_WRITE = 0; MEM_ADDRESS = 0; MEM_WRITEDATA = 0; BUSYWAIT = 0.
  - Data and tag arrays are not cleared.
- Hit = valid[index] and tag[index] == ADDRESS[7:5].
- Request = READ or WRITE. If READ and WRITE are both high, WRITE takes priority and READDATA is don't-care.
- BUSYWAIT (combinational) = request and not (state == IDLE and hit).
- READDATA (combinational): byte [offset] of line [index] when READ, not WRITE, and hit; otherwise 0.
- Read hit: zero stall cycles; data is valid in the request cycle.
- Write hit: at the rising edge in IDLE with BUSYWAIT low, store WRITEDATA into byte [offset] and set dirty[index] = 1.
- States:
  - IDLE:
    - request, miss, valid and dirty line -> WRITE_BACK.
    - request, miss, otherwise -> MEM_FETCH.
    - otherwise stay.
  - WRITE_BACK:
    - MEM_WRITE = 1; MEM_ADDRESS = {stored tag, index}; MEM_WRITEDATA = stored line.
    - At a rising edge with MEM_BUSYWAIT = 0 -> MEM_FETCH.
  - MEM_FETCH:
    - MEM_READ = 1; MEM_ADDRESS = {ADDRESS[7:5], index}.
    - At a rising edge with MEM_BUSYWAIT = 0: line <= MEM_READDATA, tag <= ADDRESS[7:5], valid = 1, dirty = 0; -> IDLE.
- After a miss the access completes in IDLE as a hit in the following cycle: a read presents data; a write writes the byte and sets dirty.
- Strobes are 0 in IDLE. MEM_ADDRESS and MEM_WRITEDATA are held stable for the whole state.
- Stall cycles with memory latency L (cycles with MEM_BUSYWAIT high, plus the completing cycle):
  - Clean miss: L + 1.
  - Dirty miss: 2L + 1.
- Request deasserted mid-miss: the current memory transaction, and a fetch following a write-back, still complete; the line fills and nothing is written from the CPU. ADDRESS must stay stable while BUSYWAIT is high.
- Reset mid-operation: strobes drop immediately and the in-flight transaction is abandoned. Dirty data is lost; memory is not corrupted.
- Index wrap: lines are independent; addresses 0x00 and 0x20 conflict on line 0.

Test Plan:
- Reset, then READ 0x00; memory returns 0x44332211 after 5 busy cycles -> MEM_READ = 1 with MEM_ADDRESS = 0x00, BUSYWAIT high for 6 cycles, then READDATA = 0x11. Follow with READ 0x03 -> 0x44 and BUSYWAIT never high.
- WRITE 0x01 with data 0xAA on a valid line -> no strobe, BUSYWAIT stays 0. Next READ 0x01 -> 0xAA, and line 0 is dirty.
- READ 0x21 (line 0 dirty, stored tag 0) -> MEM_WRITE with MEM_ADDRESS = 0x00 and MEM_WRITEDATA = 0x4433AA11, then MEM_READ with MEM_ADDRESS = 0x08, then READDATA = byte 1 of the fetched block.
- WRITE miss 0x44 with data 0x5C on a clean line -> fetch only (MEM_ADDRESS = 0x11, no MEM_WRITE). Byte 0 = 0x5C afterwards and the line is dirty.
- Assert RESET during MEM_FETCH -> MEM_READ and BUSYWAIT drop in the same cycle. Re-READ the same address after release -> miss again.
- READ and WRITE both high to a hit address with data 0x77 -> write occurs. A later READ returns 0x77.
